// File: rtl/amo_sequencer_pkg.sv
// Shared constants for the RV32A atomic sequencer: ALU control codes reused
// from the core, AMO funct5 encodings, and the sequencer state type.
package amo_sequencer_pkg;

  localparam int ALU_CTRL_WIDTH = 5;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_ADD_ADDI = 5'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_XOR_XORI = 5'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_OR_ORI   = 5'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_AND_ANDI = 5'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_LUI      = 5'd11;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MIN      = 5'd20;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MAX      = 5'd21;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MINU     = 5'd22;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MAXU     = 5'd23;

  localparam logic [4:0] AMO_F5_ADD  = 5'b00000;
  localparam logic [4:0] AMO_F5_SWAP = 5'b00001;
  localparam logic [4:0] AMO_F5_LR   = 5'b00010;
  localparam logic [4:0] AMO_F5_SC   = 5'b00011;
  localparam logic [4:0] AMO_F5_XOR  = 5'b00100;
  localparam logic [4:0] AMO_F5_OR   = 5'b01000;
  localparam logic [4:0] AMO_F5_AND  = 5'b01100;
  localparam logic [4:0] AMO_F5_MIN  = 5'b10000;
  localparam logic [4:0] AMO_F5_MAX  = 5'b10100;
  localparam logic [4:0] AMO_F5_MINU = 5'b11000;
  localparam logic [4:0] AMO_F5_MAXU = 5'b11100;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_RD,
    S_CALC,
    S_WR,
    S_DONE
  } state_t;

endpackage

// File: rtl/amo_ctrl_decode.sv
// Combinational AMO funct5 -> ALU control decode. valid is low for any
// funct5 that is not a read-modify-write AMO (LR/SC and reserved codes).
module amo_ctrl_decode
  import amo_sequencer_pkg::*;
(
  input  logic [4:0]                funct5,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  output logic                      valid
);

  // Map each AMO to the ALU operation that produces the value to store.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    alu_ctrl = ALU_CTRL_ADD_ADDI;
    valid    = 1'b1;
    case (funct5)
      AMO_F5_SWAP: alu_ctrl = ALU_CTRL_LUI;
      AMO_F5_ADD:  alu_ctrl = ALU_CTRL_ADD_ADDI;
      AMO_F5_XOR:  alu_ctrl = ALU_CTRL_XOR_XORI;
      AMO_F5_AND:  alu_ctrl = ALU_CTRL_AND_ANDI;
      AMO_F5_OR:   alu_ctrl = ALU_CTRL_OR_ORI;
      AMO_F5_MIN:  alu_ctrl = ALU_CTRL_MIN;
      AMO_F5_MAX:  alu_ctrl = ALU_CTRL_MAX;
      AMO_F5_MINU: alu_ctrl = ALU_CTRL_MINU;
      AMO_F5_MAXU: alu_ctrl = ALU_CTRL_MAXU;
      default:     valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/amo_sequencer.sv
// Multicycle RV32A read-modify-write sequencer: one load, one ALU cycle,
// one store, then a done pulse carrying the old memory word.
// Optional LR/SC support with a single reservation is enabled by defining
// AMO_LRSC_EN; without it LR/SC are reported as unknown (err).
module amo_sequencer
  import amo_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [4:0]                funct5,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [XLEN-1:0]           rs2,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [XLEN-1:0]           rd_data,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [3:0]                mem_wstrb,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [XLEN-1:0]           mem_wdata,
  input  logic [XLEN-1:0]           mem_rdata,
  output logic [XLEN-1:0]           alu_a,
  output logic [XLEN-1:0]           alu_b,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [XLEN-1:0]           alu_result
);

  state_t                    state;
  logic [ADDR_W-1:0]         word_addr;
  logic [ALU_CTRL_WIDTH-1:0] dec_ctrl;
  logic                      dec_valid;
  logic                      is_lr, is_sc, sc_hit;
  logic                      lr_q, sc_q;

  assign word_addr = {addr[ADDR_W-1:2], 2'b00};

  amo_ctrl_decode u_decode (
    .funct5   (funct5),
    .alu_ctrl (dec_ctrl),
    .valid    (dec_valid)
  );

`ifdef AMO_LRSC_EN
  logic              res_valid;
  logic [ADDR_W-1:0] res_addr;

  assign is_lr  = (funct5 == AMO_F5_LR);
  assign is_sc  = (funct5 == AMO_F5_SC);
  assign sc_hit = res_valid && (res_addr == word_addr);
`else
  assign is_lr  = 1'b0;
  assign is_sc  = 1'b0;
  assign sc_hit = 1'b0;
`endif

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_data   <= '0;
      mem_valid <= 1'b0;
      mem_wstrb <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= ALU_CTRL_ADD_ADDI;
      lr_q      <= 1'b0;
      sc_q      <= 1'b0;
`ifdef AMO_LRSC_EN
      res_valid <= 1'b0;
      res_addr  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            alu_b    <= rs2;
            alu_ctrl <= dec_ctrl;
            mem_addr <= word_addr;
            lr_q     <= is_lr;
            sc_q     <= is_sc;
            if ((addr[1:0] != 2'b00) || !(dec_valid || is_lr || is_sc)) begin
              err     <= 1'b1;
              done    <= 1'b1;
              rd_data <= '0;
              state   <= S_DONE;
            end else if (is_sc) begin
              if (sc_hit) begin
                mem_wdata <= rs2;
                mem_wstrb <= 4'b1111;
                mem_valid <= 1'b1;
                state     <= S_WR;
              end else begin
                done    <= 1'b1;
                rd_data <= XLEN'(1);
                state   <= S_DONE;
              end
            end else begin
              mem_wstrb <= 4'b0000;
              mem_valid <= 1'b1;
              state     <= S_RD;
            end
`ifdef AMO_LRSC_EN
            if (is_sc) res_valid <= 1'b0;
`endif
          end
        end
        S_RD: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            alu_a     <= mem_rdata;
            if (lr_q) begin
              done    <= 1'b1;
              rd_data <= mem_rdata;
              state   <= S_DONE;
`ifdef AMO_LRSC_EN
              res_valid <= 1'b1;
              res_addr  <= mem_addr;
`endif
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          mem_wdata <= alu_result;
          mem_wstrb <= 4'b1111;
          mem_valid <= 1'b1;
          state     <= S_WR;
        end
        S_WR: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'b0000;
            done      <= 1'b1;
            rd_data   <= sc_q ? '0 : alu_a;
            state     <= S_DONE;
`ifdef AMO_LRSC_EN
            if (res_addr == mem_addr) res_valid <= 1'b0;
`endif
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/amo_sequencer.md
Name: amo_sequencer

Overview:
- Multicycle read-modify-write engine for RV32A atomics (AMOSWAP/ADD/XOR/AND/OR/MIN/MAX/MINU/MAXU) in the kianv multicycle core.
- Initiator on the ALU interface: drives operands and `alucontrol`, and consumes `result`.
- Initiator on the memory valid/ready bus: one load, then one store.
- The control unit hands off one AMO; the block returns the old memory value for rd.

Parameters:
- ADDR_W, 32, memory address width
- XLEN, 32, data width (fixed 32 for rv32)

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, accepted only in IDLE
- funct5  in  5  AMO funct5 from instr[31:27]
- addr  in  ADDR_W  rs1 value (target address)
- rs2  in  XLEN  rs2 operand
- busy  out  1  high from accept until done
- done  out  1  one-cycle completion pulse
- err  out  1  misaligned flag, valid with done
- rd_data  out  XLEN  old memory value (SC: 0 success / 1 fail), valid with done
- mem_valid  out  1  request valid
- mem_ready  in  1  request accepted/completed
- mem_wstrb  out  4  0000 read, 1111 write
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  XLEN  store data
- mem_rdata  in  XLEN  load data, sampled on mem_valid&&mem_ready&&wstrb==0
- alu_a  out  XLEN  loaded value
- alu_b  out  XLEN  latched rs2
- alu_ctrl  out  `ALU_CTRL_WIDTH  ALU operation
- alu_result  in  XLEN  ALU result, combinational from alu_a/alu_b/alu_ctrl

Behaviour:
- Reset (async, resetn=0): state IDLE; busy, done, err, mem_valid = 0; mem_wstrb = 0; rd_data, mem_addr, mem_wdata, alu_a, alu_b = 0. Any in-flight transfer is abandoned immediately; mem_valid drops in the same instant.
- IDLE: on start, latch funct5, addr, rs2; busy=1.
  - addr[1:0]!=0 → DONE with err=1; no memory access.
  - Otherwise → RD.
  - start while busy is ignored.
- RD: mem_valid=1, wstrb=0000, mem_addr={addr[31:2],2'b00}. Hold all request signals stable until mem_ready. On the ready cycle, latch mem_rdata into old_q (drives alu_a) → CALC.
- CALC: exactly one cycle. Drive alu_ctrl from the funct5 map below; latch alu_result into wdata_q → WR.
- WR: mem_valid=1, wstrb=1111, mem_wdata=wdata_q. Hold stable until mem_ready → DONE.
- DONE: done=1, rd_data=old_q, busy=0 in the following cycle → IDLE.
- mem_valid is never asserted outside RD/WR; mem_valid deasserts in the cycle after ready.
- funct5 map to ALU control:
  - 00001 SWAP → ALU_CTRL_LUI (passes b)
  - 00000 → ADD_ADDI
  - 00100 → XOR_XORI
  - 01100 → AND_ANDI
  - 01000 → OR_ORI
  - 10000 → MIN
  - 10100 → MAX
  - 11000 → MINU
  - 11100 → MAXU
- Unknown funct5 (LR/SC when the feature is off): DONE with err=1, no memory access.
- Minimum latency with mem_ready tied high: start→done = 5 cycles (RD, CALC, WR, DONE, plus accept edge).

Optional Feature:
- Macro: AMO_LRSC_EN.
- Defined:
  - Adds a reservation register (valid bit + word address).
  - LR (00010): RD only, skip CALC/WR; set reservation, rd_data=loaded value.
  - SC (00011): if reservation valid and address matches → WR with rs2, rd_data=0. Otherwise no memory access, rd_data=1.
  - Any SC clears the reservation; any AMO write to the reserved word clears it; reset clears it.
- Undefined: LR/SC funct5 is treated as unknown (err=1); no reservation logic is synthesised.

Decomposition:
- riscv_defines.vh gains the AMO funct5 constants (AMO_F5_ADD, AMO_F5_SWAP, ...) and the state encoding width.
- The ALU_CTRL_* codes are reused unchanged.
- One natural sub-module: amo_ctrl_decode (combinational funct5 → alu_ctrl plus a valid flag), so it can be checked exhaustively.

Test Plan:
- AMOADD, mem[0x100]=5, rs2=3, ready tied high → write 8 to 0x100; rd_data=5; done at cycle 5.
- AMOMIN, mem=0xFFFFFFFE, rs2=1 → write 0xFFFFFFFE; AMOMINU, same values → write 1; both return 0xFFFFFFFE.
- Misaligned, addr=0x102 → done+err, mem_valid never high, busy low after.
- mem_ready delayed 3 cycles in both RD and WR → addr/wstrb/wdata stable throughout; rd_data correct; start pulse mid-op ignored.
- resetn low during WR → mem_valid, busy low asynchronously; next start runs cleanly.
- With AMO_LRSC_EN: LR 0x200, SC 0x200 → write, rd=0; second SC → no write, rd=1; LR then AMOSWAP 0x200 then SC → rd=1.
